// File: rtl/ccr_save_restore.sv
// CCR flag save/restore LIFO for interrupt entry and RTI return.
// Define CCR_NEST_EN for a 4-deep nested stack; otherwise a single entry is held.
module ccr_save_restore (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] flags_in,
   input  logic       int_req,
   input  logic       rti_req,
   input  logic       stall,
   output logic       int_ack,
   output logic       rti_ack,
   output logic       restore_valid,
   output logic [3:0] restore_flags,
   output logic [2:0] depth,
   output logic       ovf_err,
   output logic       unf_err
);

`ifdef CCR_NEST_EN
   localparam int DEPTH_MAX = 4;
   localparam int DW        = 3;
`else
   localparam int DEPTH_MAX = 1;
   localparam int DW        = 1;
`endif

   localparam logic [DW-1:0] FULL = DW'(DEPTH_MAX);

   typedef enum logic [1:0] {IDLE, INT_DONE, RTI_DONE} state_t;

   state_t        state_q;
   logic [DW-1:0] depth_q, depth_d;
   logic [3:0]    stack_q [DEPTH_MAX];
   logic [3:0]    stack_d [DEPTH_MAX];
   logic          int_ack_q, rti_ack_q, restore_valid_q, ovf_err_q, unf_err_q;
   logic [3:0]    restore_flags_q;
   logic          push, pop;

   // Entry 0 is always the top of stack; pushes shift older entries down.
   assign push = (state_q == IDLE) && !stall && int_req && (depth_q != FULL);
   assign pop  = (state_q == RTI_DONE) && (depth_q != '0);

   always_comb begin
      stack_d = stack_q;
      depth_d = depth_q;
      if (push) begin
         stack_d[0] = flags_in;
         for (int i = 1; i < DEPTH_MAX; i++)
            stack_d[i] = stack_q[i-1];
         depth_d = depth_q + DW'(1);
      end else if (pop) begin
         for (int i = 0; i < DEPTH_MAX - 1; i++)
            stack_d[i] = stack_q[i+1];
         stack_d[DEPTH_MAX-1] = 4'h0;
         depth_d = depth_q - DW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth_q <= '0;
         for (int i = 0; i < DEPTH_MAX; i++)
            stack_q[i] <= 4'h0;
      end else begin
         depth_q <= depth_d;
         stack_q <= stack_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         int_ack_q       <= 1'b0;
         rti_ack_q       <= 1'b0;
         restore_valid_q <= 1'b0;
         restore_flags_q <= 4'h0;
         ovf_err_q       <= 1'b0;
         unf_err_q       <= 1'b0;
      end else begin
         int_ack_q       <= 1'b0;
         rti_ack_q       <= 1'b0;
         restore_valid_q <= 1'b0;
         restore_flags_q <= 4'h0;
         case (state_q)
            IDLE: begin
               if (!stall) begin
                  if (int_req) begin
                     state_q   <= INT_DONE;
                     int_ack_q <= 1'b1;
                     if (depth_q == FULL)
                        ovf_err_q <= 1'b1;
                  end else if (rti_req) begin
                     state_q   <= RTI_DONE;
                     rti_ack_q <= 1'b1;
                     if (depth_q != '0) begin
                        restore_valid_q <= 1'b1;
                        restore_flags_q <= stack_q[0];
                     end else begin
                        unf_err_q <= 1'b1;
                     end
                  end
               end
            end
            INT_DONE: state_q <= IDLE;
            RTI_DONE: state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

   assign int_ack       = int_ack_q;
   assign rti_ack       = rti_ack_q;
   assign restore_valid = restore_valid_q;
   assign restore_flags = restore_flags_q;
   assign ovf_err       = ovf_err_q;
   assign unf_err       = unf_err_q;

`ifdef CCR_NEST_EN
   assign depth = depth_q;
`else
   assign depth = {2'b00, depth_q};
`endif

endmodule

// File: doc/ccr_save_restore.md
CCR_SAVE_RESTORE -- requirements
Module: ccr_save_restore

Interface
REQ-001 SHALL have: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: flags_in  in  4  forwarded current flags {C,N,Z,V} to be preserved on interrupt entry.
REQ-004 SHALL have: int_req  in  1  interrupt-entry save request, level, held until int_ack.
REQ-005 SHALL have: rti_req  in  1  RTI restore request, level, held until rti_ack.
REQ-006 SHALL have: stall  in  1  pipeline stall; blocks acceptance of new requests.
REQ-007 SHALL have: int_ack  out  1  one-cycle pulse, save request completed.
REQ-008 SHALL have: rti_ack  out  1  one-cycle pulse, restore request completed.
REQ-009 SHALL have: restore_valid  out  1  one-cycle write strobe into the CCR write-back update path.
REQ-010 SHALL have: restore_flags  out  4  flags to write into CCR, meaningful only while restore_valid=1.
REQ-011 SHALL have: depth  out  3  number of saved flag entries currently held.
REQ-012 SHALL have: ovf_err  out  1  sticky, save attempted while stack full.
REQ-013 SHALL have: unf_err  out  1  sticky, restore attempted while stack empty.

Function
REQ-014 SHALL implement a LIFO of 4-bit entries with capacity DEPTH_MAX (see Configuration).
REQ-015 SHALL use FSM states IDLE, INT_DONE, RTI_DONE.
REQ-016 IDLE: stall=1 -> stay IDLE, no push/pop, all pulse outputs 0.
REQ-017 IDLE, stall=0, int_req=1: push flags_in sampled at that edge if depth<DEPTH_MAX, depth+1; go INT_DONE.
REQ-018 IDLE, stall=0, int_req=0, rti_req=1: go RTI_DONE; no stack change on that edge.
REQ-019 int_req and rti_req both high in IDLE: int_req served first; rti_req served after return to IDLE.
REQ-020 INT_DONE: int_ack=1 for exactly one cycle, then IDLE unconditionally (stall ignored).
REQ-021 RTI_DONE with depth>0: rti_ack=1, restore_valid=1, restore_flags=top entry for one cycle; pop at cycle end, depth-1; then IDLE.
REQ-022 RTI_DONE with depth=0: rti_ack=1, restore_valid=0, restore_flags=0, unf_err set; then IDLE.
REQ-023 Save with depth=DEPTH_MAX: no push, depth unchanged, ovf_err set, int_ack still pulses via INT_DONE.
REQ-024 Latency: request accepted at edge N -> ack (and restore_valid) high in cycle N+1; minimum 2 cycles between accepted requests.
REQ-025 depth SHALL never exceed DEPTH_MAX nor wrap below 0.
REQ-026 restore_flags SHALL be 0 whenever restore_valid=0.
REQ-027 ovf_err/unf_err SHALL stay set until reset.
REQ-028 Requester drops request in cycle after ack; a request still high in IDLE is treated as new.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, depth=0, all stack entries 0, int_ack=rti_ack=restore_valid=0, restore_flags=0, ovf_err=unf_err=0.
REQ-030 rst asserted in INT_DONE/RTI_DONE SHALL abort the pulse with no pop/push after reset release.

Configuration
REQ-031 Macro CCR_NEST_EN defined: DEPTH_MAX=4, nested interrupts supported.
REQ-032 CCR_NEST_EN undefined: DEPTH_MAX=1; second save with one entry held sets ovf_err; depth output upper bits constant 0.

Verification
REQ-033 flags_in=4'b1010, int_req -> int_ack next cycle, depth=1; rti_req -> restore_valid=1, restore_flags=4'b1010, depth=0.
REQ-034 With CCR_NEST_EN: saves 4'h1,4'h2,4'h3,4'h4 then 4 restores -> restore_flags 4'h4,4'h3,4'h2,4'h1; fifth save -> ovf_err=1, depth=4.
REQ-035 rti_req with depth=0 -> rti_ack=1, restore_valid=0, unf_err=1 held through later traffic until rst.
REQ-036 int_req and rti_req high together, depth=1 holding 4'h5, flags_in=4'h9 -> int_ack first (depth=2), then restore_flags=4'h9.
REQ-037 stall=1 for 3 cycles with int_req high -> no ack during stall; int_ack one cycle after stall deasserts.
REQ-038 rst pulsed during RTI_DONE with depth=2 -> depth=0, restore_valid=0 immediately, no error flags set.
